tim_nhi_phan: RTL and testbench

- Binary-search (successive-approximation) controller placed around the 4-bit magnitude comparator.
- Drives the probe value into the comparator's `a` input. The unknown target sits on `b`.
- Consumes the comparator's one-hot flags `x` (a>b), `y` (a<b) and `z` (a==b).
- Converges on the target in at most W+1 probes. Reports the found value, the probe count and a done pulse.

---
 rtl/tim_nhi_phan_if.sv | 29 ++
 rtl/tim_nhi_phan.sv | 141 ++++++++++++++
 tb/tb_tim_nhi_phan.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/tim_nhi_phan_if.sv
// Handshake bundle between the binary-search controller and its comparator/host.
// master: host + comparator side; slave: the tim_nhi_phan controller.
`timescale 1ns/1ps
interface tim_nhi_phan_if #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 3
);
  logic          start;
  logic          x_in;
  logic          y_in;
  logic          z_in;
  logic [W-1:0]  guess;
  logic          busy;
  logic          done;
  logic          found;
  logic [W-1:0]  result;
  logic [CW-1:0] steps;
  logic          err;

  modport master (
    output start, x_in, y_in, z_in,
    input  guess, busy, done, found, result, steps, err
  );

  modport slave (
    input  start, x_in, y_in, z_in,
    output guess, busy, done, found, result, steps, err
  );
endinterface

// File: rtl/tim_nhi_phan.sv
// Successive-approximation search driving a magnitude comparator's `a` input.
// Optional flag-violation checking is enabled by defining TIM_NHI_PHAN_ERR_CHECK_EN.
`timescale 1ns/1ps
module tim_nhi_phan #(
  parameter int unsigned W  = 4,
  parameter int unsigned CW = 3
) (
  input logic           clk,
  input logic           rst,
  tim_nhi_phan_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StProbe, StFinish} state_e;

  localparam logic [W-1:0] GuessInit = {1'b0, {(W-1){1'b1}}};

  state_e        state_q;
  logic [W-1:0]  lo_q, hi_q, guess_q, result_q;
  logic [CW-1:0] steps_q;
  logic          busy_q, done_q, found_q;

  logic [W-1:0]  lo_d, hi_d, guess_d;
  logic [CW-1:0] steps_inc;
  logic          stop, hit;

  assign steps_inc = (steps_q == '1) ? steps_q : steps_q + 1'b1;

`ifdef TIM_NHI_PHAN_ERR_CHECK_EN
  logic err_q;
  logic fault;
  assign fault   = !$onehot({bus.x_in, bus.y_in, bus.z_in});
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // One probe step: midpoint sums are formed at W+1 bits so lo+hi never wraps.
  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    guess_d = guess_q;
    stop    = 1'b0;
    hit     = 1'b0;
    if (bus.z_in) begin
      stop = 1'b1;
      hit  = 1'b1;
    end else if (bus.x_in) begin
      if (guess_q == '0) begin
        stop = 1'b1;
      end else begin
        hi_d = guess_q - 1'b1;
        if (lo_q > hi_d) stop = 1'b1;
        else guess_d = W'(({1'b0, lo_q} + {1'b0, hi_d}) >> 1);
      end
    end else if (bus.y_in) begin
      if (guess_q == '1) begin
        stop = 1'b1;
      end else begin
        lo_d = guess_q + 1'b1;
        if (lo_d > hi_q) stop = 1'b1;
        else guess_d = W'(({1'b0, lo_d} + {1'b0, hi_q}) >> 1);
      end
    end else if (steps_inc == '1) begin
      stop = 1'b1;
    end
`ifdef TIM_NHI_PHAN_ERR_CHECK_EN
    if (fault) begin
      lo_d    = lo_q;
      hi_d    = hi_q;
      guess_d = guess_q;
      stop    = 1'b1;
      hit     = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      lo_q     <= '0;
      hi_q     <= '1;
      guess_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      result_q <= '0;
      steps_q  <= '0;
`ifdef TIM_NHI_PHAN_ERR_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (bus.start) begin
            lo_q     <= '0;
            hi_q     <= '1;
            guess_q  <= GuessInit;
            steps_q  <= '0;
            found_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= StProbe;
`ifdef TIM_NHI_PHAN_ERR_CHECK_EN
            err_q    <= 1'b0;
`endif
          end
        end
        StProbe: begin
          steps_q <= steps_inc;
          lo_q    <= lo_d;
          hi_q    <= hi_d;
          guess_q <= guess_d;
          if (stop) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            found_q <= hit;
            if (hit) result_q <= guess_q;
            state_q <= StFinish;
`ifdef TIM_NHI_PHAN_ERR_CHECK_EN
            err_q   <= fault;
`endif
          end
        end
        StFinish: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.guess  = guess_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.found  = found_q;
  assign bus.result = result_q;
  assign bus.steps  = steps_q;

endmodule

// File: tb/tb_tim_nhi_phan.sv
// Bench for tim_nhi_phan: comparator environment plus an interval-search reference model.
`timescale 1ns/1ps
module tb_tim_nhi_phan;

  localparam int W    = 4;
  localparam int CW   = 3;
  localparam int MaxG = 15;
  localparam int MaxS = 7;

  logic clk = 1'b0;
  logic rst;
  int   mode;
  int   target;
  int   n_cmp = 0;
  int   n_err = 0;

  int exp_q[$];
  int exp_found, exp_result, exp_steps, exp_err;

  always #5 clk = ~clk;

  tim_nhi_phan_if #(.W(W), .CW(CW)) bus ();

  tim_nhi_phan #(.W(W), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // mode 0: real comparator, 1: y stuck, 2: x stuck, 3: x and y, 4: no flag
  function automatic logic [2:0] cmp_flags(input int md, input int g, input int t);
    case (md)
      0:       return {g > t, g < t, g == t};
      1:       return 3'b010;
      2:       return 3'b100;
      3:       return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  always_comb begin
    {bus.x_in, bus.y_in, bus.z_in} = cmp_flags(mode, int'(bus.guess), target);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Interval search over [lo,hi] straight from the search rules.
  task automatic model(input int md, input int t);
    int lo, hi, g, s;
    logic [2:0] f;
    bit fin;
    exp_q.delete();
    exp_found = 0; exp_result = 0; exp_err = 0;
    lo = 0; hi = MaxG; g = (lo + hi) / 2; s = 0; fin = 0;
    while (!fin) begin
      exp_q.push_back(g);
      s++;
      f = cmp_flags(md, g, t);
`ifdef TIM_NHI_PHAN_ERR_CHECK_EN
      if (int'(f[2]) + int'(f[1]) + int'(f[0]) != 1) begin
        exp_err = 1;
        fin = 1;
      end else
`endif
      if (f[0]) begin
        exp_found = 1; exp_result = g; fin = 1;
      end else if (f[2]) begin
        if (g == 0) fin = 1;
        else begin
          hi = g - 1;
          if (lo > hi) fin = 1; else g = (lo + hi) / 2;
        end
      end else if (f[1]) begin
        if (g == MaxG) fin = 1;
        else begin
          lo = g + 1;
          if (lo > hi) fin = 1; else g = (lo + hi) / 2;
        end
      end else if (s == MaxS) begin
        fin = 1;
      end
    end
    exp_steps = s;
  endtask

  task automatic run_search(input int md, input int t, input bit glitch);
    int cyc, idx, last;
    model(md, t);
    last = exp_q[exp_q.size() - 1];
    @(negedge clk);
    mode = md; target = t; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; idx = 0;
    while (!bus.done && cyc < 40) begin
      chk("busy_probe", bus.busy, 1);
      chk($sformatf("guess[%0d] t=%0d m=%0d", idx, t, md), bus.guess,
          (idx < exp_q.size()) ? exp_q[idx] : -1);
      bus.start = glitch && (idx == 1);
      idx++;
      @(posedge clk); #1;
      cyc++;
    end
    bus.start = 1'b0;
    chk("done_seen", bus.done, 1);
    chk("done_latency", cyc, exp_steps + 1);
    chk("busy_at_done", bus.busy, 0);
    chk("steps", bus.steps, exp_steps);
    chk("found", bus.found, exp_found);
    chk("result", bus.result, exp_result);
    chk("err", bus.err, exp_err);
    chk("guess_final", bus.guess, last);
    @(posedge clk); #1;
    chk("done_one_cycle", bus.done, 0);
    chk("busy_after", bus.busy, 0);
    chk("guess_hold", bus.guess, last);
    chk("found_hold", bus.found, exp_found);
    chk("result_hold", bus.result, exp_result);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_guess"}, bus.guess, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_found"}, bus.found, 0);
    chk({tag, "_result"}, bus.result, 0);
    chk({tag, "_steps"}, bus.steps, 0);
    chk({tag, "_err"}, bus.err, 0);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; mode = 0; target = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    rst = 1'b0;

    run_search(0, 11, 0);
    run_search(0, 0, 0);
    run_search(0, 15, 0);
    run_search(1, 0, 0);
    run_search(2, 0, 0);

    // Abandon a search at guess 11 with an asynchronous reset.
    @(negedge clk);
    mode = 0; target = 11; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("rst_seq_g0", bus.guess, 7);
    @(posedge clk); #1;
    chk("rst_seq_g1", bus.guess, 11);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", bus.done, 0);
      chk("idle_after_rst", bus.busy, 0);
    end

    run_search(0, 5, 1);
    run_search(3, 0, 0);
    run_search(4, 0, 0);

    for (int i = 0; i < 24; i++) begin
      int md;
      md = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(1, 4));
      run_search(md, int'($urandom_range(0, MaxG)), bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
